// File: rtl/sub12u_0lb_pipe.sv
`timescale 1ns/1ps
// Approximate 12-bit subtractor: the low nibble passes through and only a borrow guess feeds the high byte.
// Two-stage valid/ready pipe (latency 2, one transfer per cycle), O holds while stalled. SUB12U_ERRMON_EN adds an error monitor.
module sub12u_0lb_pipe (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [11:0] A,
  input  logic [11:0] B,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [12:0] O,
  input  logic        err_clr,
  output logic [3:0]  max_err,
  output logic [15:0] err_cnt
);

  typedef struct packed {
    logic [7:0] a_hi;
    logic [7:0] b_hi;
    logic [3:0] a_lo;
    logic       bin;
  } s1_t;

  logic        s1_valid;
  logic        s2_valid;
  s1_t         s1_dat;
  logic [12:0] o_dat;
  logic        s2_adv;
  logic        s1_adv;
  logic [8:0]  hi_diff;
  logic [12:0] o_next;

  assign s2_adv    = ~s2_valid | out_ready;
  assign s1_adv    = ~s1_valid | s2_adv;
  // The pipe is treated as empty while reset is held.
  assign in_ready  = ~rst_n | s1_adv;
  assign out_valid = s2_valid;
  assign O         = o_dat;

  // The 9-bit difference wraps modulo 256 and bit 8 is the borrow out.
  assign hi_diff = {1'b0, s1_dat.a_hi} - {1'b0, s1_dat.b_hi} - {8'd0, s1_dat.bin};
  assign o_next  = {hi_diff, s1_dat.a_lo};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s1_dat   <= '0;
      o_dat    <= '0;
    end else begin
      if (s1_adv) begin
        s1_valid <= in_valid;
        if (in_valid)
          s1_dat <= '{a_hi: A[11:4], b_hi: B[11:4], a_lo: A[3:0], bin: B[3] & ~A[3]};
      end
      if (s2_adv) begin
        s2_valid <= s1_valid;
        if (s1_valid)
          o_dat <= o_next;
      end
    end
  end

`ifdef SUB12U_ERRMON_EN
  logic signed [12:0] s1_e;
  logic [3:0]         s2_err;
  logic [3:0]         max_q;
  logic [15:0]        cnt_q;
  logic signed [13:0] err_diff;
  logic [3:0]         err_next;
  logic               unused_diff_hi;

  // The approximation error never exceeds 15, so only the low nibble of the magnitude matters.
  assign err_diff       = $signed({o_next[12], o_next}) - $signed({s1_e[12], s1_e});
  assign err_next       = err_diff[13] ? (4'd0 - err_diff[3:0]) : err_diff[3:0];
  assign unused_diff_hi = ^err_diff[12:4];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_e   <= '0;
      s2_err <= '0;
      max_q  <= '0;
      cnt_q  <= '0;
    end else begin
      if (s1_adv && in_valid)
        s1_e <= $signed({1'b0, A}) - $signed({1'b0, B});
      if (s2_adv && s1_valid)
        s2_err <= err_next;
      if (err_clr) begin
        max_q <= '0;
        cnt_q <= '0;
      end else if (s2_valid && out_ready) begin
        if (s2_err > max_q)
          max_q <= s2_err;
        if (s2_err != 4'd0 && cnt_q != 16'hFFFF)
          cnt_q <= cnt_q + 16'd1;
      end
    end
  end

  assign max_err = max_q;
  assign err_cnt = cnt_q;
`else
  logic unused_in;

  assign max_err   = '0;
  assign err_cnt   = '0;
  assign unused_in = ^{err_clr, B[2:0]};
`endif

endmodule

// File: tb/tb_sub12u_0lb_pipe.sv
`timescale 1ns/1ps
// Randomized and directed bench for sub12u_0lb_pipe, scored against an integer-arithmetic reference queue.
module tb_sub12u_0lb_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] A;
  logic [11:0] B;
  logic        out_valid;
  logic        out_ready;
  logic [12:0] O;
  logic        err_clr;
  logic [3:0]  max_err;
  logic [15:0] err_cnt;

`ifdef SUB12U_ERRMON_EN
  localparam bit MON = 1'b1;
`else
  localparam bit MON = 1'b0;
`endif

  typedef struct {
    logic [12:0] o;
    int          err;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   mx_m = 0;
  int   cnt_m = 0;
  int   n_in = 0;
  int   n_out = 0;
  bit   saw_block = 1'b0;

  sub12u_0lb_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready), .O(O),
    .err_clr(err_clr), .max_err(max_err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [12:0] ref_o(input logic [11:0] a, input logic [11:0] b);
    int bin, d;
    logic [7:0] dh;
    logic bo;
    bin = (b[3] && !a[3]) ? 1 : 0;
    d   = int'(a[11:4]) - int'(b[11:4]) - bin;
    bo  = (d < 0);
    dh  = 8'((d + 256) % 256);
    return {bo, dh, a[3:0]};
  endfunction

  function automatic int ref_err(input logic [11:0] a, input logic [11:0] b, input logic [12:0] o);
    int e, ap, df;
    e  = int'(a) - int'(b);
    ap = int'(o[11:0]) - (o[12] ? 4096 : 0);
    df = ap - e;
    return (df < 0) ? -df : df;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scores one clock: handshakes are judged mid-cycle, monitor outputs just after the edge.
  task automatic cyc();
    exp_t e;
    logic [12:0] ro;
    #1;
    if (!rst_n) begin
      q.delete();
      mx_m  = 0;
      cnt_m = 0;
    end else begin
      if (out_valid === 1'b1) begin
        chk("out_valid_has_expected", q.size() != 0, 1);
        if (q.size() != 0) begin
          chk("O_vs_model", O, q[0].o);
          if (out_ready) begin
            e = q.pop_front();
            n_out++;
            if (e.err > mx_m) mx_m = e.err;
            if (e.err != 0 && cnt_m < 65535) cnt_m++;
          end
        end
      end
      if (err_clr) begin
        mx_m  = 0;
        cnt_m = 0;
      end
      if (in_valid && in_ready === 1'b1) begin
        ro = ref_o(A, B);
        q.push_back('{o: ro, err: ref_err(A, B, ro)});
        n_in++;
      end
      if (in_valid && in_ready === 1'b0) saw_block = 1'b1;
    end
    @(posedge clk);
    #1;
    chk("max_err", max_err, MON ? mx_m : 0);
    chk("err_cnt", err_cnt, MON ? cnt_m : 0);
  endtask

  task automatic single(input logic [11:0] a, input logic [11:0] b, input logic [12:0] eo,
                        input int emx, input int ecnt);
    A = a; B = b; in_valid = 1'b1; out_ready = 1'b1;
    cyc();
    in_valid = 1'b0;
    chk("lat1_out_valid", out_valid, 0);
    cyc();
    chk("lat2_out_valid", out_valid, 1);
    chk("lat2_O", O, eo);
    cyc();
    chk("dir_max_err", max_err, MON ? emx : 0);
    chk("dir_err_cnt", err_cnt, MON ? ecnt : 0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; err_clr = 1'b0; A = '0; B = '0;
    cyc();
    cyc();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_O", O, 0);
    rst_n = 1'b1;
    #1;
    chk("release_in_ready", in_ready, 1);

    single(12'h050, 12'h030, 13'h0020, 0, 0);
    single(12'h100, 12'h001, 13'h0100, 1, 1);
    single(12'h000, 12'h010, 13'h1FF0, 1, 1);
    err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
    chk("clr_max_err", max_err, 0);
    chk("clr_err_cnt", err_cnt, 0);
    single(12'h000, 12'h008, 13'h1FF0, 8, 1);
    single(12'h008, 12'h008, 13'h0008, 8, 2);

    // Eight-operand stream with a three-cycle consumer stall.
    n_in = 0; n_out = 0; saw_block = 1'b0;
    for (int c = 0; c < 60 && (n_in < 8 || n_out < 8); c++) begin
      in_valid  = (n_in < 8);
      A         = 12'($urandom);
      B         = 12'($urandom);
      out_ready = !(c >= 3 && c < 6);
      cyc();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("stream_accepted", n_in, 8);
    chk("stream_delivered", n_out, 8);
    chk("stream_in_ready_dropped", saw_block, 1);

    // Reset with two operands stuck in the pipe.
    out_ready = 1'b0; in_valid = 1'b1; A = 12'h123; B = 12'h045;
    cyc();
    A = 12'h456; B = 12'h789;
    cyc();
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", in_ready, 1);
    cyc();
    chk("mid_rst_out_valid", out_valid, 0);
    rst_n = 1'b1;
    #1;
    chk("mid_release_in_ready", in_ready, 1);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("no_stale_out", out_valid, 0);
    end

    // Clear asserted on the same cycle as an erroneous output transfer.
    single(12'h000, 12'h008, 13'h1FF0, 8, 1);
    A = 12'h000; B = 12'h008; in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    cyc();
    chk("clr_xfer_pending", out_valid, 1);
    err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
    chk("clr_xfer_max_err", max_err, 0);
    chk("clr_xfer_err_cnt", err_cnt, 0);

    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      A         = 12'($urandom);
      B         = ($urandom_range(0, 7) == 0) ? A : 12'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      err_clr   = ($urandom_range(0, 29) == 0);
      cyc();
    end
    in_valid = 1'b0; out_ready = 1'b1; err_clr = 1'b0;
    for (int i = 0; i < 6; i++) cyc();
    chk("drain_queue_empty", q.size(), 0);
    chk("drain_out_valid", out_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
